// File: rtl/i2c_disp_master.sv
// I2C write-only master mirroring a 16-byte shadow register file into the display controller.
// Optional I2C_DISP_BURST_EN: chain consecutive dirty bytes into one transaction without STOP.
module i2c_disp_master #(
  parameter int unsigned CLK_DIV   = 16,
  parameter logic [6:0]  SLAVE_ADR = 7'h38,
  parameter int unsigned RETRIES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  output logic       busy,
  output logic       nack_err
);

  localparam int unsigned TW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {StIdle, StStart, StAddr, StReg, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bitc_q, bitc_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    tx_q, tx_d;
  logic          nack_q, nack_d;
  logic          fail_q, fail_d;
  logic [7:0]    retry_q, retry_d;
  logic [15:0]   dirty_q, dirty_d;
  logic          nack_err_q, nack_err_d;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic [7:0]    ram_q [16];
  logic          tick;
  logic [3:0]    low_idx;
  logic [7:0]    cur_byte;

`ifdef I2C_DISP_BURST_EN
  logic [3:0] idx_nxt;
  assign idx_nxt = idx_q + 4'd1;
`endif

  assign tick     = (tmr_q == TW'(CLK_DIV - 1));
  assign busy     = (state_q != StIdle) || (|dirty_q);
  assign nack_err = nack_err_q;
  assign scl_out  = scl_q;
  assign sda_out  = sda_q;

  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (dirty_q[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    qtr_d      = qtr_q;
    bitc_d     = bitc_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    nack_d     = nack_q;
    fail_d     = fail_q;
    retry_d    = retry_q;
    dirty_d    = dirty_q;
    nack_err_d = wr_en ? 1'b0 : nack_err_q;

    if (state_q != StIdle) tmr_d = tick ? '0 : tmr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (|dirty_q) begin
          idx_d            = low_idx;
          tx_d             = ram_q[low_idx];
          dirty_d[low_idx] = 1'b0;
          fail_d           = 1'b0;
          qtr_d            = '0;
          bitc_d           = '0;
          tmr_d            = '0;
          state_d          = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (qtr_q == 2'd1) begin
            qtr_d   = '0;
            bitc_d  = '0;
            state_d = StAddr;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      StAddr, StReg, StData: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2 && bitc_q == 4'd8) nack_d = sda_in;
          if (qtr_q == 2'd3) begin
            if (bitc_q != 4'd8) begin
              bitc_d = bitc_q + 4'd1;
            end else begin
              bitc_d = '0;
              if (nack_q) begin
                fail_d  = 1'b1;
                state_d = StStop;
              end else if (state_q == StAddr) begin
                state_d = StReg;
              end else if (state_q == StReg) begin
                state_d = StData;
              end else begin
`ifdef I2C_DISP_BURST_EN
                if (idx_q != 4'hf && dirty_q[idx_nxt]) begin
                  idx_d            = idx_nxt;
                  tx_d             = ram_q[idx_nxt];
                  dirty_d[idx_nxt] = 1'b0;
                end else begin
                  state_d = StStop;
                end
`else
                state_d = StStop;
`endif
              end
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (!fail_q) begin
              retry_d = '0;
              state_d = StIdle;
            end else if (retry_q < 8'(RETRIES)) begin
              retry_d = retry_q + 8'd1;
              fail_d  = 1'b0;
              state_d = StStart;
            end else begin
              nack_err_d = 1'b1;
              retry_d    = '0;
              fail_d     = 1'b0;
              state_d    = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A CPU write in the same cycle as a latch wins, so the byte is resent later.
    if (wr_en) dirty_d[wr_addr] = 1'b1;
  end

  // Pin levels are decoded from next-state so the registered pins line up with the state.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (state_d)
      StAddr:  cur_byte = {SLAVE_ADR, 1'b0};
      StReg:   cur_byte = {4'h0, idx_d};
      default: cur_byte = tx_d;
    endcase
    unique case (state_d)
      StStart: begin
        sda_d = 1'b0;
        scl_d = (qtr_d == 2'd0);
      end
      StAddr, StReg, StData: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_d = (bitc_d == 4'd8) ? 1'b1 : cur_byte[~bitc_d[2:0]];
      end
      StStop: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      qtr_q      <= '0;
      bitc_q     <= '0;
      idx_q      <= '0;
      tx_q       <= '0;
      nack_q     <= 1'b0;
      fail_q     <= 1'b0;
      retry_q    <= '0;
      dirty_q    <= '0;
      nack_err_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      qtr_q      <= qtr_d;
      bitc_q     <= bitc_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      nack_q     <= nack_d;
      fail_q     <= fail_d;
      retry_q    <= retry_d;
      dirty_q    <= dirty_d;
      nack_err_q <= nack_err_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
    end else if (wr_en) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_disp_master.sv
// Directed bench for i2c_disp_master: bus decoder plus ACK/NACK slave model on the wired-AND SDA.
// Burst expectations switch with I2C_DISP_BURST_EN.
module tb_i2c_disp_master;

  localparam int Div     = 4;
  localparam int MaxWait = 20000;
  localparam int EvStart = 'h100;
  localparam int EvStop  = 'h200;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       scl_out, sda_out, sda_in, busy, nack_err;
  logic       slv_sda = 1'b1;
  logic       bus_sda;

  int n_checks = 0;
  int n_fail   = 0;
  int ev[$];
  int exp_q[$];
  bit nack_addr = 1'b0;

  assign bus_sda = sda_out & slv_sda;
  assign sda_in  = bus_sda;

  always #5 clk = ~clk;

  i2c_disp_master #(
    .CLK_DIV  (Div),
    .SLAVE_ADR(7'h38),
    .RETRIES  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .scl_out (scl_out),
    .sda_out (sda_out),
    .sda_in  (sda_in),
    .busy    (busy),
    .nack_err(nack_err)
  );

  // Bus decoder and slave: logs START/STOP/bytes, ACKs every byte unless told to NACK the address.
  initial begin
    logic       pscl, psda, cur;
    logic [7:0] sh;
    int         bitn, byten;
    bit         in_ack;
    pscl = 1'b1; psda = 1'b1; sh = '0; bitn = 0; byten = 0; in_ack = 1'b0;
    forever begin
      @(negedge clk);
      cur = bus_sda;
      if (reset) begin
        pscl = 1'b1; psda = 1'b1; bitn = 0; byten = 0; in_ack = 1'b0; slv_sda = 1'b1;
      end else begin
        if (scl_out && pscl && psda && !cur) begin
          ev.push_back(EvStart);
          bitn = 0; byten = 0; in_ack = 1'b0; slv_sda = 1'b1;
        end else if (scl_out && pscl && !psda && cur) begin
          ev.push_back(EvStop);
        end else if (scl_out && !pscl) begin
          if (bitn < 8) begin
            sh = {sh[6:0], cur};
            bitn++;
            if (bitn == 8) begin
              ev.push_back(int'(sh));
              byten++;
            end
          end else begin
            bitn = 0;
          end
        end else if (!scl_out && pscl) begin
          if (in_ack) begin
            slv_sda = 1'b1;
            in_ack  = 1'b0;
          end else if (bitn == 8) begin
            in_ack  = 1'b1;
            slv_sda = (nack_addr && byten == 1);
          end
        end
        pscl = scl_out;
        psda = cur;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic wr_end();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    int n = 0;
    while (busy && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    cyc = n;
    if (n >= MaxWait) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_ev(input int cnt);
    int n = 0;
    while (ev.size() < cnt && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    if (n >= MaxWait) check_eq("ev_timeout", ev.size(), cnt);
  endtask

  task automatic push_txn(input int idx, input int d);
    exp_q.push_back(EvStart); exp_q.push_back('h70); exp_q.push_back(idx);
    exp_q.push_back(d);       exp_q.push_back(EvStop);
  endtask

  task automatic compare_ev(input string tag);
    check_eq({tag, "_len"}, ev.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++)
      check_eq($sformatf("%s_ev%0d", tag, i), ev[i], exp_q[i]);
    ev.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc, bad;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (5) @(negedge clk);
    check_eq("rst_scl", scl_out, 1);
    check_eq("rst_sda", sda_out, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_nack_err", nack_err, 0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (scl_out !== 1'b1 || sda_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("quiet_bus", bad, 0);
    check_eq("quiet_events", ev.size(), 0);

    // Single byte with exact busy length.
    wr(4'd3, 8'hA5); wr_end();
    wait_idle(cyc);
    check_eq("busy_len", cyc, 114 * Div + 1);
    check_eq("single_nack_err", nack_err, 0);
    push_txn(3, 'hA5);
    compare_ev("single");

    // Two writes queued behind an in-flight byte: lowest index goes first.
    wr(4'd9, 8'h99); wr_end();
    wait_ev(2);
    wr(4'd7, 8'h11); wr(4'd2, 8'h22); wr_end();
    wait_idle(cyc);
    push_txn(9, 'h99); push_txn(2, 'h22); push_txn(7, 'h11);
    compare_ev("order");

    // Address NACK every time: three attempts, then the byte is dropped.
    nack_addr = 1'b1;
    wr(4'd12, 8'h3C); wr_end();
    wait_idle(cyc);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(EvStart); exp_q.push_back('h70); exp_q.push_back(EvStop);
    end
    compare_ev("nack");
    check_eq("nack_err_set", nack_err, 1);
    check_eq("nack_busy", busy, 0);
    nack_addr = 1'b0;
    wr(4'd1, 8'h5A); wr_end();
    check_eq("nack_err_clr", nack_err, 0);
    wait_idle(cyc);
    push_txn(1, 'h5A);
    compare_ev("after_nack");

    // Rewrite of the in-flight index during DATA: old value goes out, then new one.
    wr(4'd5, 8'h01); wr_end();
    wait_ev(3);
    repeat (16 * Div) @(negedge clk);
    wr(4'd5, 8'h02); wr_end();
    wait_idle(cyc);
    push_txn(5, 'h01); push_txn(5, 'h02);
    compare_ev("rewrite");

    // Three adjacent indices.
    wr(4'd4, 8'h44); wr(4'd5, 8'h55); wr(4'd6, 8'h66); wr_end();
    wait_idle(cyc);
`ifdef I2C_DISP_BURST_EN
    exp_q.push_back(EvStart); exp_q.push_back('h70); exp_q.push_back('h04);
    exp_q.push_back('h44); exp_q.push_back('h55); exp_q.push_back('h66);
    exp_q.push_back(EvStop);
`else
    push_txn(4, 'h44); push_txn(5, 'h55); push_txn(6, 'h66);
`endif
    compare_ev("adjacent");

    // Index 0 dirtied while 15 is in flight must not be chained after 15.
    wr(4'd15, 8'hF0); wr_end();
    wait_ev(3);
    wr(4'd0, 8'h0A); wr_end();
    wait_idle(cyc);
    push_txn(15, 'hF0); push_txn(0, 'h0A);
    compare_ev("no_wrap");
    check_eq("end_nack_err", nack_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
